stream_source: RTL and testbench

- Synthesizable producer for the handshaked stream element type {field0: i64 data, field1: EOS flag}.
- Feeds a DUT's stream input port and is the transmit-side counterpart of the stream consumers in our integration benches.
- One accepted control token launches an arithmetic sequence of COUNT elements, then one EOS element, then one output control token.
- Used in stream-dialect integration benches and as an on-chip test pattern generator.

---
 rtl/stream_source_pkg.sv | 20 ++
 rtl/stream_source_seq.sv | 44 ++++
 rtl/stream_source.sv | 131 +++++++++++++
 tb/tb_stream_source.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_source_pkg.sv
// Shared types and defaults for the stream_source test-pattern producer.
// Optional feature macro used by the top: STREAM_SOURCE_STALL_STATS_EN.
package stream_source_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        EOS  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W_DEF-1:0] field0;
        logic                  field1;
    } stream_elem_t;

endpackage

// File: rtl/stream_source_seq.sv
// Arithmetic-sequence datapath: holds the running value, step and remaining count.
module stream_source_seq
    import stream_source_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [DATA_W-1:0] start,
    input  logic [DATA_W-1:0] step,
    input  logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] value_next,
    output logic              last,
    output logic              empty
);

    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] step_q;
    logic [CNT_W-1:0]  remaining;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value     <= '0;
            step_q    <= '0;
            remaining <= '0;
        end else if (load) begin
            value     <= start;
            step_q    <= step;
            remaining <= count;
        end else if (advance) begin
            value     <= value_next;
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Wrap modulo 2^DATA_W is the natural truncation of the sum.
    assign value_next = value + step_q;
    assign last       = (remaining == CNT_W'(1));
    assign empty      = (count == '0);

endmodule

// File: rtl/stream_source.sv
// Handshaked stream producer: one start token -> COUNT data elements, EOS, done token.
// Optional stall-cycle statistics output enabled by STREAM_SOURCE_STALL_STATS_EN.
module stream_source
    import stream_source_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inCtrl_valid,
    output logic              inCtrl_ready,
    input  logic [DATA_W-1:0] cfg_start,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [CNT_W-1:0]  cfg_count,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data_field0,
    output logic              out0_data_field1,
    output logic              outCtrl_valid,
    input  logic              outCtrl_ready,
    output logic              busy
`ifdef STREAM_SOURCE_STALL_STATS_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    state_t            state;
    logic              in_hs;
    logic              out_hs;
    logic              seq_advance;
    logic [DATA_W-1:0] value_next;
    logic              last;
    logic              empty;

    assign in_hs       = inCtrl_valid && inCtrl_ready;
    assign out_hs      = out0_valid && out0_ready;
    assign seq_advance = (state == EMIT) && out_hs;

    stream_source_seq #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_seq (
        .clock      (clock),
        .reset      (reset),
        .load       (in_hs),
        .advance    (seq_advance),
        .start      (cfg_start),
        .step       (cfg_step),
        .count      (cfg_count),
        .value_next (value_next),
        .last       (last),
        .empty      (empty)
    );

    // Outputs are registered; each transition loads the values of the state being entered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            inCtrl_ready     <= 1'b0;
            out0_valid       <= 1'b0;
            out0_data_field0 <= '0;
            out0_data_field1 <= 1'b0;
            outCtrl_valid    <= 1'b0;
            busy             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_hs) begin
                        inCtrl_ready <= 1'b0;
                        busy         <= 1'b1;
                        out0_valid   <= 1'b1;
                        if (empty) begin
                            state            <= EOS;
                            out0_data_field0 <= '0;
                            out0_data_field1 <= 1'b1;
                        end else begin
                            state            <= EMIT;
                            out0_data_field0 <= cfg_start;
                            out0_data_field1 <= 1'b0;
                        end
                    end else begin
                        inCtrl_ready <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_hs) begin
                        if (last) begin
                            state            <= EOS;
                            out0_data_field0 <= '0;
                            out0_data_field1 <= 1'b1;
                        end else begin
                            out0_data_field0 <= value_next;
                        end
                    end
                end
                EOS: begin
                    if (out_hs) begin
                        state            <= DONE;
                        out0_valid       <= 1'b0;
                        out0_data_field1 <= 1'b0;
                        outCtrl_valid    <= 1'b1;
                    end
                end
                DONE: begin
                    if (outCtrl_valid && outCtrl_ready) begin
                        state         <= IDLE;
                        outCtrl_valid <= 1'b0;
                        busy          <= 1'b0;
                        inCtrl_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STREAM_SOURCE_STALL_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (in_hs) begin
            stall_cycles <= '0;
        end else if (out0_valid && !out0_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_source.sv
// Self-checking bench for stream_source against an arithmetic reference sequence.
// Covers STREAM_SOURCE_STALL_STATS_EN when that macro is defined.
module tb_stream_source;
    import stream_source_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        inCtrl_valid;
    logic        inCtrl_ready;
    logic [63:0] cfg_start;
    logic [63:0] cfg_step;
    logic [15:0] cfg_count;
    logic        out0_valid;
    logic        out0_ready;
    logic [63:0] out0_data_field0;
    logic        out0_data_field1;
    logic        outCtrl_valid;
    logic        outCtrl_ready;
    logic        busy;
`ifdef STREAM_SOURCE_STALL_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned last_stalls = 0;

    always #5 clock = ~clock;

    stream_source #(
        .DATA_W (64),
        .CNT_W  (16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .inCtrl_valid     (inCtrl_valid),
        .inCtrl_ready     (inCtrl_ready),
        .cfg_start        (cfg_start),
        .cfg_step         (cfg_step),
        .cfg_count        (cfg_count),
        .out0_valid       (out0_valid),
        .out0_ready       (out0_ready),
        .out0_data_field0 (out0_data_field0),
        .out0_data_field1 (out0_data_field1),
        .outCtrl_valid    (outCtrl_valid),
        .outCtrl_ready    (outCtrl_ready),
        .busy             (busy)
`ifdef STREAM_SOURCE_STALL_STATS_EN
        ,
        .stall_cycles     (stall_cycles)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble_cfg();
        cfg_start = {$urandom, $urandom};
        cfg_step  = {$urandom, $urandom};
        cfg_count = 16'($urandom);
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the start handshake.
    task automatic start_seq(input logic [63:0] start, input logic [63:0] step,
                             input logic [15:0] count, input string tag);
        inCtrl_valid = 1'b1;
        cfg_start = start;
        cfg_step  = step;
        cfg_count = count;
        check({tag, "_in_rdy"}, inCtrl_ready, 1);
        check({tag, "_idle_busy"}, busy, 0);
        @(negedge clock);
        inCtrl_valid = 1'b0;
        scramble_cfg();
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_rdy_lo"}, inCtrl_ready, 0);
        check({tag, "_v_first"}, out0_valid, 1);
    endtask

    // Expected stream: start + i*step for i < count, then one EOS element.
    task automatic drain(input logic [63:0] start, input logic [63:0] step,
                         input logic [15:0] count, input bit rnd, input string tag);
        stream_elem_t q[$];
        stream_elem_t e;
        int unsigned  stalls = 0;
        int unsigned  budget = 0;
        bit           rdy;
        for (int unsigned i = 0; i < count; i++) begin
            e.field0 = start + step * 64'(i);
            e.field1 = 1'b0;
            q.push_back(e);
        end
        e.field0 = '0;
        e.field1 = 1'b1;
        q.push_back(e);
        while (q.size() != 0 && budget < 400) begin
            check({tag, "_valid"}, out0_valid, 1);
            check({tag, "_f0"}, out0_data_field0, q[0].field0);
            check({tag, "_f1"}, out0_data_field1, 64'(q[0].field1));
            check({tag, "_in_rdy"}, inCtrl_ready, 0);
            check({tag, "_octl"}, outCtrl_valid, 0);
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            out0_ready = rdy;
            if (rdy) void'(q.pop_front());
            else stalls++;
            budget++;
            @(negedge clock);
        end
        out0_ready = 1'($urandom_range(0, 1));
        check({tag, "_timeout"}, 64'(q.size()), 0);
        check({tag, "_v_after"}, out0_valid, 0);
        check({tag, "_octl_up"}, outCtrl_valid, 1);
`ifdef STREAM_SOURCE_STALL_STATS_EN
        check({tag, "_stalls"}, stall_cycles, 64'(stalls));
`endif
        last_stalls = stalls;
    endtask

    task automatic finish_ctrl(input int unsigned hold, input string tag);
        outCtrl_ready = 1'b0;
        for (int unsigned i = 0; i < hold; i++) begin
            check({tag, "_octl_hold"}, outCtrl_valid, 1);
            check({tag, "_in_blocked"}, inCtrl_ready, 0);
            check({tag, "_busy_hold"}, busy, 1);
            @(negedge clock);
        end
        check({tag, "_octl_pre"}, outCtrl_valid, 1);
        outCtrl_ready = 1'b1;
        @(negedge clock);
        outCtrl_ready = 1'b0;
        check({tag, "_octl_down"}, outCtrl_valid, 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_in_rdy_back"}, inCtrl_ready, 1);
`ifdef STREAM_SOURCE_STALL_STATS_EN
        check({tag, "_stalls_held"}, stall_cycles, 64'(last_stalls));
`endif
    endtask

    // Called at a negedge; asserts reset between edges and checks the asynchronous clear.
    task automatic async_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        check({tag, "_v"}, out0_valid, 0);
        check({tag, "_f0"}, out0_data_field0, 0);
        check({tag, "_f1"}, out0_data_field1, 0);
        check({tag, "_octl"}, outCtrl_valid, 0);
        check({tag, "_busy"}, busy, 0);
`ifdef STREAM_SOURCE_STALL_STATS_EN
        check({tag, "_stalls"}, stall_cycles, 0);
`endif
        inCtrl_valid  = 1'b0;
        out0_ready    = 1'b0;
        outCtrl_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check({tag, "_in_rdy_rel"}, inCtrl_ready, 1);
        check({tag, "_v_rel"}, out0_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rs, rt;
        logic [15:0] rc;

        reset         = 1'b0;
        inCtrl_valid  = 1'b0;
        out0_ready    = 1'b0;
        outCtrl_ready = 1'b0;
        scramble_cfg();
        @(negedge clock);
        check("rst_v", out0_valid, 0);
        check("rst_f0", out0_data_field0, 0);
        check("rst_f1", out0_data_field1, 0);
        check("rst_octl", outCtrl_valid, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clock);
        check("rel_in_rdy", inCtrl_ready, 1);

        // Basic sequence, ready held high
        start_seq(64'd5, 64'd1, 16'd3, "t1");
        drain(64'd5, 64'd1, 16'd3, 1'b0, "t1");
        finish_ctrl(0, "t1");

        // Zero-length sequence
        start_seq(64'd77, 64'd9, 16'd0, "t2");
        drain(64'd77, 64'd9, 16'd0, 1'b0, "t2");
        finish_ctrl(1, "t2");

        // Value wrap-around
        start_seq(64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 16'd3, "t3");
        drain(64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 16'd3, 1'b0, "t3");
        finish_ctrl(0, "t3");

        // Random backpressure
        start_seq(64'd10, 64'd3, 16'd4, "t4");
        drain(64'd10, 64'd3, 16'd4, 1'b1, "t4");
        finish_ctrl(2, "t4");

        // Reset after two elements of a ten-element run
        start_seq(64'd100, 64'd7, 16'd10, "t5");
        check("t5_e0", out0_data_field0, 100);
        out0_ready = 1'b1;
        @(negedge clock);
        check("t5_e1", out0_data_field0, 107);
        @(negedge clock);
        check("t5_e2_shown", out0_data_field0, 114);
        async_reset("t5_rst");
        start_seq(64'd0, 64'd1, 16'd2, "t5b");
        drain(64'd0, 64'd1, 16'd2, 1'b0, "t5b");
        finish_ctrl(0, "t5b");

        // Start token held during a stalled completion token
        start_seq(64'd1000, 64'd5, 16'd2, "t6");
        drain(64'd1000, 64'd5, 16'd2, 1'b0, "t6");
        inCtrl_valid = 1'b1;
        cfg_start = 64'd50;
        cfg_step  = 64'd4;
        cfg_count = 16'd3;
        finish_ctrl(5, "t6");
        @(negedge clock);
        inCtrl_valid = 1'b0;
        scramble_cfg();
        check("t6_second_busy", busy, 1);
        check("t6_second_v", out0_valid, 1);
        drain(64'd50, 64'd4, 16'd3, 1'b1, "t6b");
        // Reset while the completion token is pending
        async_reset("t6_rst");

        // Randomized sequences
        for (int k = 0; k < 6; k++) begin
            rs = {$urandom, $urandom};
            rt = {$urandom, $urandom};
            rc = 16'($urandom_range(0, 6));
            start_seq(rs, rt, rc, "rnd");
            drain(rs, rt, rc, 1'b1, "rnd");
            finish_ctrl($urandom_range(0, 3), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
